// File: rtl/ciaa_kbd_receiver.sv
// CIA-A receiver for the Amiga serial keyboard link: 8-bit shift-in, decode, host handshake, KDAT pull-low.
// Optional special-code trapping is enabled with `define CIAA_KBD_SPECIAL_CODES_EN.
module ciaa_kbd_receiver #(
  parameter int HS_LEN  = 600,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic       kbdata_oe,
  output logic       key_valid,
  output logic [6:0] key_code,
  output logic       key_up,
  input  logic       keyack,
  output logic       overrun,
  output logic       timeout_err,
  output logic       special_strobe,
  output logic [7:0] special_code
);
  localparam int CW = $clog2((HS_LEN > TIMEOUT) ? HS_LEN : TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HS} state_e;

  state_e        state_q, state_d;
  logic [1:0]    kbclk_s_q, kbdata_s_q;
  logic          kbclk_prev_q;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [6:0]    sr_q, sr_d;
  logic [CW-1:0] tmo_q, tmo_d, hs_q, hs_d;
  logic          oe_q, oe_d, kv_q, kv_d, up_q, up_d, ovr_q, ovr_d, terr_q, terr_d;
  logic [6:0]    code_q, code_d;

  logic       rise, sbit, byte_done, is_special;
  logic [7:0] raw, dec;

  assign rise = clk7_en & kbclk_s_q[1] & ~kbclk_prev_q;
  assign sbit = kbdata_s_q[1];
  assign raw  = {sr_q, sbit};
  assign dec  = {~raw[0], ~raw[7:1]};

`ifdef CIAA_KBD_SPECIAL_CODES_EN
  logic       sstb_q, sstb_d;
  logic [7:0] scode_q, scode_d;
  assign is_special     = (dec == 8'h78) || (dec >= 8'hF9 && dec <= 8'hFE);
  assign special_strobe = sstb_q;
  assign special_code   = scode_q;
`else
  assign is_special     = 1'b0;
  assign special_strobe = 1'b0;
  assign special_code   = 8'h00;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    tmo_d     = tmo_q;
    hs_d      = hs_q;
    oe_d      = oe_q;
    terr_d    = clk7_en ? 1'b0 : terr_q;
    byte_done = 1'b0;
    unique case (state_q)
      S_IDLE: if (rise) begin
        sr_d     = {sr_q[5:0], sbit};
        bitcnt_d = 3'd1;
        tmo_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (rise) begin
          sr_d  = {sr_q[5:0], sbit};
          tmo_d = '0;
          if (bitcnt_q == 3'd7) begin
            byte_done = 1'b1;
            bitcnt_d  = 3'd0;
            hs_d      = '0;
            oe_d      = 1'b1;
            state_d   = S_HS;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else if (clk7_en) begin
          if (tmo_q == CW'(TIMEOUT - 1)) begin
            terr_d   = 1'b1;
            bitcnt_d = 3'd0;
            tmo_d    = '0;
            state_d  = S_IDLE;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
      end
      // kbclk edges are deliberately ignored while KDAT is held low
      S_HS: if (clk7_en) begin
        if (hs_q == CW'(HS_LEN - 1)) begin
          oe_d    = 1'b0;
          hs_d    = '0;
          state_d = S_IDLE;
        end else begin
          hs_d = hs_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Host handshake runs on every clk; a same-clk key write overrides keyack.
  always_comb begin
    kv_d   = keyack ? 1'b0 : kv_q;
    code_d = code_q;
    up_d   = up_q;
    ovr_d  = ovr_q;
`ifdef CIAA_KBD_SPECIAL_CODES_EN
    sstb_d  = clk7_en ? 1'b0 : sstb_q;
    scode_d = scode_q;
`endif
    if (byte_done) begin
      if (is_special) begin
`ifdef CIAA_KBD_SPECIAL_CODES_EN
        sstb_d  = 1'b1;
        scode_d = dec;
`endif
      end else begin
        kv_d   = 1'b1;
        code_d = dec[6:0];
        up_d   = dec[7];
        if (kv_q && !keyack) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbclk_s_q    <= 2'b11;
      kbdata_s_q   <= 2'b11;
      kbclk_prev_q <= 1'b1;
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      sr_q         <= '0;
      tmo_q        <= '0;
      hs_q         <= '0;
      oe_q         <= 1'b0;
      kv_q         <= 1'b0;
      code_q       <= '0;
      up_q         <= 1'b0;
      ovr_q        <= 1'b0;
      terr_q       <= 1'b0;
`ifdef CIAA_KBD_SPECIAL_CODES_EN
      sstb_q       <= 1'b0;
      scode_q      <= '0;
`endif
    end else begin
      kbclk_s_q  <= {kbclk_s_q[0], kbclk};
      kbdata_s_q <= {kbdata_s_q[0], kbdata};
      if (clk7_en) kbclk_prev_q <= kbclk_s_q[1];
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sr_q       <= sr_d;
      tmo_q      <= tmo_d;
      hs_q       <= hs_d;
      oe_q       <= oe_d;
      kv_q       <= kv_d;
      code_q     <= code_d;
      up_q       <= up_d;
      ovr_q      <= ovr_d;
      terr_q     <= terr_d;
`ifdef CIAA_KBD_SPECIAL_CODES_EN
      sstb_q     <= sstb_d;
      scode_q    <= scode_d;
`endif
    end
  end

  assign kbdata_oe   = oe_q;
  assign key_valid   = kv_q;
  assign key_code    = code_q;
  assign key_up      = up_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_ciaa_kbd_receiver.sv
// Directed + randomized bench for ciaa_kbd_receiver against a byte-level key model.
module tb_ciaa_kbd_receiver;
  localparam int HS_LEN  = 600;
  localparam int TIMEOUT = 1023;

  logic       clk, reset, clk7_en, kbclk, kbdata, keyack;
  logic       kbdata_oe, key_valid, key_up, overrun, timeout_err, special_strobe;
  logic [6:0] key_code;
  logic [7:0] special_code;

  ciaa_kbd_receiver #(.HS_LEN(HS_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .kbclk(kbclk), .kbdata(kbdata),
    .kbdata_oe(kbdata_oe), .key_valid(key_valid), .key_code(key_code), .key_up(key_up),
    .keyack(keyack), .overrun(overrun), .timeout_err(timeout_err),
    .special_strobe(special_strobe), .special_code(special_code)
  );

  // clk7_en alternates and settles mid-high-phase, so at each negedge it already
  // holds the enable for the coming posedge.
  initial begin
    clk = 0; clk7_en = 0;
    forever begin #5 clk = 1; #2 clk7_en = ~clk7_en; #3 clk = 0; end
  end

  int n_pass = 0, n_total = 0, n_fail = 0;
  int n_tmo = 0, n_spec = 0, n_oe = 0;
  logic tmo_p = 0, spec_p = 0, oe_p = 0;

  always @(negedge clk) begin
    if (timeout_err && !tmo_p) n_tmo++;
    if (special_strobe && !spec_p) n_spec++;
    if (kbdata_oe && !oe_p) n_oe++;
    tmo_p = timeout_err; spec_p = special_strobe; oe_p = kbdata_oe;
  end

  // Reference model state
  bit       e_valid, e_over, e_up;
  bit [6:0] e_code;
  bit [7:0] e_scode;
  int       e_nspec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] decode(input logic [7:0] r);
    int n;
    n = 255 - int'(r);
    return 8'((n >> 1) + ((n % 2) * 128));
  endfunction

  function automatic logic [7:0] encode(input logic [7:0] k);
    int n;
    n = (int'(k) * 2) % 256 + int'(k) / 128;
    return 8'(255 - n);
  endfunction

  function automatic bit is_special(input logic [7:0] k);
`ifdef CIAA_KBD_SPECIAL_CODES_EN
    return (k == 8'h78) || (k >= 8'hF9 && k <= 8'hFE);
`else
    return 1'b0;
`endif
  endfunction

  task automatic ticks(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  // Sends the first n bits of r, MSB first. Optionally pulses keyack on exactly
  // the clk whose tick sees the final rising edge (2-flop sync + tick compare).
  task automatic send_bits(input logic [7:0] r, input int n, input bit ack_last);
    logic en1;
    logic [7:0] rv;
    rv = r;
    for (int i = 0; i < n; i++) begin
      kbdata = rv[7 - i];
      kbclk  = 0;
      ticks($urandom_range(4, 20));
      kbclk  = 1;
      if (i == n - 1) begin
        if (ack_last) begin
          en1 = clk7_en;
          repeat (2) @(negedge clk);
          if (!en1) @(negedge clk);
          keyack = 1;
          @(negedge clk);
          keyack = 0;
        end
      end else begin
        ticks($urandom_range(4, 20));
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] r, input bit ack_c);
    logic [7:0] k;
    k = decode(r);
    if (is_special(k)) begin
      if (ack_c) e_valid = 0;
      e_scode = k;
      e_nspec++;
    end else begin
      if (e_valid && !ack_c) e_over = 1;
      e_valid = 1;
      e_code  = k[6:0];
      e_up    = k[7];
    end
  endtask

  task automatic send_byte(input logic [7:0] r, input bit ack_last);
    int w, c;
    send_bits(r, 8, ack_last);
    model_byte(r, ack_last);
    w = 0;
    while (kbdata_oe !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    chk("hs_start", kbdata_oe, 1);
    chk("kv_latency", key_valid, e_valid);
    c = 0; w = 0;
    while (kbdata_oe === 1'b1 && w < 4 * HS_LEN) begin
      if (clk7_en) c++;
      @(negedge clk); w++;
    end
    chk("hs_len", c, HS_LEN);
    chk("key_valid", key_valid, e_valid);
    chk("key_code", key_code, e_code);
    chk("key_up", key_up, e_up);
    chk("overrun", overrun, e_over);
    chk("spec_cnt", n_spec, e_nspec);
`ifdef CIAA_KBD_SPECIAL_CODES_EN
    chk("spec_code", special_code, e_scode);
`endif
    ticks(3);
  endtask

  task automatic ack();
    keyack = 1;
    @(negedge clk);
    keyack = 0;
    e_valid = 0;
    chk("ack_clear", key_valid, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_kv"}, key_valid, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_up"}, key_up, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_oe"}, kbdata_oe, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_sstb"}, special_strobe, 0);
    chk({tag, "_scode"}, special_code, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    @(negedge clk);
    chk_zero(tag);
    reset = 0;
    e_valid = 0; e_over = 0; e_up = 0; e_code = 0; e_scode = 0;
    ticks(4);
  endtask

  initial begin
    int t0, o0, w;
    logic [7:0] r;
    bit al;
    keyack = 0; kbclk = 1; kbdata = 1; reset = 1;
    e_valid = 0; e_over = 0; e_up = 0; e_code = 0; e_scode = 0; e_nspec = 0;
    repeat (4) @(negedge clk);
    chk_zero("rst");
    reset = 0;
    ticks(4);

    send_byte(8'h75, 0);
    chk("d75_code", key_code, 7'h45);
    chk("d75_up", key_up, 0);
    ack();
    send_byte(8'h74, 0);
    chk("d74_code", key_code, 7'h45);
    chk("d74_up", key_up, 1);
    ack();

    send_byte(8'h75, 0);
    send_byte(8'h74, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_up", key_up, 1);

    do_reset("rst2");
    send_byte(8'h75, 0);
    send_byte(8'h74, 1);
    chk("coinc_kv", key_valid, 1);
    chk("coinc_ovr", overrun, 0);
    ack();

    t0 = n_tmo; o0 = n_oe;
    send_bits(8'h75, 3, 0);
    ticks(1000);
    chk("tmo_early", n_tmo, t0);
    ticks(60);
    chk("tmo_once", n_tmo, t0 + 1);
    chk("tmo_no_hs", n_oe, o0);
    chk("tmo_no_kv", key_valid, 0);
    send_byte(8'h75, 0);
    chk("post_tmo_code", key_code, 7'h45);
    ack();

    send_byte(8'h04, 0);
`ifdef CIAA_KBD_SPECIAL_CODES_EN
    chk("fd_scode", special_code, 8'hFD);
    chk("fd_kv", key_valid, 0);
`else
    chk("fd_kv", key_valid, 1);
    chk("fd_code", key_code, 7'h7D);
    chk("fd_up", key_up, 1);
`endif

    send_bits(8'h75, 5, 0);
    ticks(3);
    do_reset("rst_bit5");
    send_bits(8'h75, 8, 0);
    w = 0;
    while (kbdata_oe !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    chk("mid_hs_oe", kbdata_oe, 1);
    ticks(100);
    do_reset("rst_hs");
    send_byte(8'h75, 0);
    chk("post_rst_code", key_code, 7'h45);
    ack();

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(0, 6);
        r = encode((w == 0) ? 8'h78 : 8'(8'hF8 + w));
      end else begin
        r = 8'($urandom);
      end
      al = ($urandom_range(0, 3) == 0);
      send_byte(r, al);
      if ($urandom_range(0, 1) == 1 && e_valid) ack();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ciaa_kbd_receiver.md
Name: ciaa_kbd_receiver

Overview:
- CIA-A side receiver for the Amiga serial keyboard link. Its input is the kbclk/kbdata pair produced by the keyboard transmitter.
- Shifts in 8 bits, MSB first, on rising kbclk, then undoes the rotate-right-and-invert encoding. Presents the key code to the host with a valid/ack handshake.
- After each byte, pulls KDAT low for a programmable time, as the Amiga handshake requires.
- Sits between the keyboard front end and the CIA-A SDR/interrupt logic.

Parameters:
- HS_LEN, 600, handshake low-pulse length in clk7_en ticks (about 85 us at 7.09 MHz).
- TIMEOUT, 1023, clk7_en ticks without a kbclk rising edge before a partial byte is discarded.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk7_en  in  1  7 MHz clock enable; all state advances only on this
- kbclk  in  1  serial keyboard clock, asynchronous
- kbdata  in  1  serial keyboard data, asynchronous
- kbdata_oe  out  1  1 = drive KDAT low (handshake)
- key_valid  out  1  key_code/key_up hold a valid unread key
- key_code  out  7  decoded key number
- key_up  out  1  1 = key release
- keyack  in  1  host consumed the key; clears key_valid
- overrun  out  1  sticky; a new key arrived while key_valid = 1
- timeout_err  out  1  one-clk7_en-tick pulse when a partial byte is discarded
- special_strobe  out  1  one-tick pulse on a special code (optional feature only)
- special_code  out  8  last special code (optional feature only)

Behaviour:
- Input sync:
  - kbclk and kbdata pass through 2-flop synchronisers on clk.
  - A rising edge is detected on clk7_en ticks, by comparing the synced kbclk with its value at the previous clk7_en tick.
  - kbdata is sampled at the same tick.
- Reset values: every output is 0. State = IDLE, bit count = 0, shift register = 0, counters = 0.
- Reset asserted mid-byte or mid-handshake aborts the operation immediately. No key is emitted and kbdata_oe drops the next clk.
- IDLE:
  - On a kbclk rising edge, shift in the sampled bit, set bit count = 1, clear the timeout counter, go to SHIFT.
- SHIFT:
  - Each rising edge shifts the sampled bit in (sr <= {sr[6:0], bit}), increments the bit count and clears the timeout counter.
  - Each tick without an edge increments the timeout counter.
  - When the counter reaches TIMEOUT: pulse timeout_err, clear the bit count, go to IDLE. No key is emitted and no handshake is driven.
  - On the 8th edge, take raw byte r (the 8 bits incl. the one just sampled).
  - Decoded k = {~r[0], ~r[7:1]}; key_up = k[7], key_code = k[6:0].
  - Write the outputs and set key_valid at that tick, then go to HANDSHAKE.
  - Latency: key_valid is visible one clk after the clk7_en tick that detects the 8th edge.
- Overrun:
  - If key_valid was already 1 when a new key is written, set overrun (sticky until reset). The old key is overwritten.
  - If keyack and a new-key write occur in the same tick, the write wins: key_valid stays 1 and overrun is not set.
  - keyack with key_valid = 0 has no effect.
- HANDSHAKE:
  - kbdata_oe = 1 for exactly HS_LEN clk7_en ticks, then 0, then go to IDLE.
  - kbclk edges during HANDSHAKE are ignored and are not counted.
- Width rules:
  - Bit counter is 3 bits plus a done condition.
  - Timeout and handshake counters are sized to $clog2 of the larger parameter plus 1.
  - No counter wraps; each saturates or is cleared by a state change.

Optional Feature:
- Macro: CIAA_KBD_SPECIAL_CODES_EN
- With the macro defined:
  - Decoded bytes k = 0x78 (reset warning) or 0xF9–0xFE (lost sync, overflow, selftest fail, init start, init end) do not set key_valid.
  - Instead they pulse special_strobe for one tick and load special_code = k.
  - The handshake is still driven. No overrun is involved.
- Without the macro: special_strobe and special_code are tied to 0. All bytes decode as ordinary keys.

Test Plan:
- Serial byte 0x75 (bit period 256 ticks, clk low at 0xc0, high at 0x40) -> key_valid = 1, key_code = 0x45, key_up = 0. kbdata_oe high for exactly 600 ticks, then IDLE.
- Byte 0x74, then keyack pulse -> key_code = 0x45, key_up = 1. key_valid clears the clk after keyack.
- Two bytes 0x75 then 0x74 with no keyack -> key_code = 0x45, key_up = 1, overrun = 1. Repeat with keyack coincident with the 2nd write -> key_valid = 1, overrun = 0.
- 3 bits then silence for 1023 ticks -> timeout_err pulses once, no key_valid, no handshake. A following 0x75 decodes correctly to 0x45.
- Byte 0x04 (k = 0xFD):
  - with macro -> special_strobe, special_code = 0xFD, key_valid = 0;
  - without macro -> key_valid, key_code = 0x7D, key_up = 1.
- Reset asserted at bit 5 and again mid-handshake -> all outputs 0 next clk. A subsequent full byte 0x75 is received normally.
